mc_ctrl: RTL and testbench
==========================

Name: mc_ctrl

Overview:
- Multi-cycle control FSM that sequences the shared MIPS datapath: instruction fetch, register-file decode/read, ALU, data memory and register write-back.
- It drives every write enable and mux select on the datapath and stalls on a memory-ready handshake.
- Opcode and funct come from the instruction register.
- It keeps a retired-instruction counter and a sticky illegal-opcode flag for the bench and for debug.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.
- PC_INC, 4, byte increment applied on fetch. Informational only: the datapath adder uses it, the FSM does not.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RST  in  1  synchronous, active-high reset.
- Op  in  6  Ins[31:26] from the instruction register.
- Funct  in  6  Ins[5:0]; decoded only when Op is R_FORM.
- Zero  in  1  ALU zero flag, used for BEQ.
- MemReady  in  1  memory has completed the current read or write this cycle.
- PCWe  out  1  PC write enable.
- PCSrc  out  2  PC source: 0 = ALU (PC+4), 1 = branch target register, 2 = jump target.
- IRWe  out  1  instruction register write enable.
- MemRe  out  1  memory read request.
- MemWe  out  1  memory write request.
- IorD  out  1  memory address select: 0 = PC, 1 = ALU result register.
- RegWe  out  1  register-file write enable.
- RegDst  out  1  write-register select: 1 = Ins[15:11], 0 = Ins[20:16].
- MemToReg  out  1  write-data select: 1 = memory data register, 0 = ALU result.
- ALUSrcA  out  1  ALU A input: 0 = PC, 1 = Rdata1.
- ALUSrcB  out  2  ALU B input: 0 = Rdata2, 1 = constant 4, 2 = Ed32, 3 = Ed32 shifted left by 2.
- ALUOp  out  2  ALU operation: 0 = add, 1 = sub, 2 = use funct.
- Illegal  out  1  sticky; set on an undefined opcode.
- RetireCnt  out  CNT_W  number of completed instructions.
- State  out  4  current state encoding, for debug.

Behaviour:
- Reset: while RST is high, the next state is FETCH, RetireCnt is 0 and Illegal is 0. All enables (PCWe, IRWe, MemRe, MemWe, RegWe) are forced to 0 during the RST cycle. Reset arriving mid-instruction abandons that instruction with no further writes.
- Output timing: all outputs are combinational from state plus MemReady and Zero, with no added latency.
- Select defaults: every select is 0 unless listed for the state below.
- FETCH:
  - Drive MemRe=1, IorD=0, ALUSrcA=0, ALUSrcB=1, ALUOp=0.
  - If MemReady=0: hold in FETCH with IRWe=0 and PCWe=0.
  - If MemReady=1: IRWe=1, PCWe=1 with PCSrc=0, next state DECODE.
- DECODE:
  - Drive ALUSrcA=0, ALUSrcB=3, ALUOp=0 to compute the branch target. The register file is read in this state.
  - Next state by Op:
    - R_FORM (000000) -> EXEC_R.
    - LW (100011) or SW (101011) -> ADDR.
    - ADDI (001000) -> EXEC_I.
    - BEQ (000100) -> BRANCH.
    - J (000010) -> JUMP.
    - Any other opcode -> set Illegal, increment RetireCnt, go to FETCH. The instruction is skipped.
- EXEC_R: ALUSrcA=1, ALUSrcB=0, ALUOp=2; next state WB_R.
- WB_R: RegWe=1, RegDst=1, MemToReg=0; retire; next state FETCH.
- EXEC_I: ALUSrcA=1, ALUSrcB=2, ALUOp=0; next state WB_I.
- WB_I: RegWe=1, RegDst=0, MemToReg=0; retire; next state FETCH.
- ADDR: ALUSrcA=1, ALUSrcB=2, ALUOp=0.
  - Op = LW -> MEM_RD.
  - Op = SW -> MEM_WR.
- MEM_RD: MemRe=1, IorD=1. Hold until MemReady=1, then go to WB_L.
- WB_L: RegWe=1, RegDst=0, MemToReg=1; retire; next state FETCH.
- MEM_WR: MemWe=1, IorD=1. Hold until MemReady=1, then retire and go to FETCH.
  - MemWe stays asserted for the whole wait. The memory side commits exactly once, on the MemReady cycle.
- BRANCH: ALUSrcA=1, ALUSrcB=0, ALUOp=1, PCSrc=1, PCWe=Zero; retire; next state FETCH.
- JUMP: PCSrc=2, PCWe=1; retire; next state FETCH.
- Retire: RetireCnt increments by 1 on each retire cycle and wraps from all-ones to 0.
- Illegal: remains 1 until the next RST.
- Unused state encodings go to FETCH on the next cycle.
- Cycle counts with MemReady tied to 1:
  - R-type: 4 cycles.
  - ADDI: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - BEQ: 3 cycles.
  - J: 3 cycles.

Decomposition:
- Shared constants in common_param.vh: the opcode values (R_FORM, LW, SW, ADDI, BEQ, J) and the ALUOp, PCSrc and ALUSrcB encodings.
- State encodings stay local to this block.
- Natural sub-module: mc_decode, a purely combinational state-to-control-vector table. The FSM next-state logic and the counters stay in mc_ctrl.

Test Plan:
- Reset: RST high for 2 cycles with MemReady=1 -> State=FETCH, RetireCnt=0, Illegal=0, all enables 0 during RST; after release, MemRe=1 in the first cycle.
- R-type: Op=000000, Funct=100000, MemReady=1 -> state trace FETCH, DECODE, EXEC_R, WB_R. RegWe=1 and RegDst=1 only in WB_R; RetireCnt goes 0 -> 1 after cycle 4.
- LW with wait states: Op=100011, MemReady low for 3 cycles in MEM_RD -> MemRe=1 and IorD=1 held throughout. WB_L arrives one cycle after MemReady=1, with RegWe=1, MemToReg=1, RegDst=0. Total 8 cycles.
- BEQ: Op=000100 run twice, Zero=1 then Zero=0 -> PCWe=1 with PCSrc=1 in BRANCH in the first run, PCWe=0 in the second. Both runs take 3 cycles, and RetireCnt increments in both.
- Illegal opcode: Op=111111 -> DECODE goes straight to FETCH with no RegWe or MemWe. Illegal=1 and stays 1 through a following valid SW, whose MemWe is asserted for exactly the MEM_WR cycles.
- Reset mid-operation: RST asserted during a MemReady-stalled MEM_WR -> MemWe=0 in the RST cycle, then FETCH follows and RetireCnt=0.
- Counter wrap: CNT_W=4, run 16 J instructions (Op=000010) -> RetireCnt wraps to 0, and each J asserts PCWe=1 with PCSrc=2.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared opcodes, select encodings, state type and control
// vector for the multi-cycle MIPS control unit.
package mc_ctrl_pkg;

   localparam logic [5:0] OP_R_FORM = 6'b000000;
   localparam logic [5:0] OP_LW     = 6'b100011;
   localparam logic [5:0] OP_SW     = 6'b101011;
   localparam logic [5:0] OP_ADDI   = 6'b001000;
   localparam logic [5:0] OP_BEQ    = 6'b000100;
   localparam logic [5:0] OP_J      = 6'b000010;

   localparam logic [1:0] ALU_ADD   = 2'd0;
   localparam logic [1:0] ALU_SUB   = 2'd1;
   localparam logic [1:0] ALU_FUNCT = 2'd2;

   localparam logic [1:0] PC_ALU    = 2'd0;
   localparam logic [1:0] PC_BR     = 2'd1;
   localparam logic [1:0] PC_JMP    = 2'd2;

   localparam logic [1:0] SRCB_REG  = 2'd0;
   localparam logic [1:0] SRCB_FOUR = 2'd1;
   localparam logic [1:0] SRCB_IMM  = 2'd2;
   localparam logic [1:0] SRCB_IMMS = 2'd3;

   typedef enum logic [3:0] {
      ST_FETCH  = 4'd0,
      ST_DECODE = 4'd1,
      ST_EXEC_R = 4'd2,
      ST_WB_R   = 4'd3,
      ST_EXEC_I = 4'd4,
      ST_WB_I   = 4'd5,
      ST_ADDR   = 4'd6,
      ST_MEM_RD = 4'd7,
      ST_WB_L   = 4'd8,
      ST_MEM_WR = 4'd9,
      ST_BRANCH = 4'd10,
      ST_JUMP   = 4'd11
   } state_t;

   typedef struct packed {
      logic       pc_we;
      logic [1:0] pc_src;
      logic       ir_we;
      logic       mem_re;
      logic       mem_we;
      logic       iord;
      logic       reg_we;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
   } ctrl_t;

endpackage

// File: rtl/mc_decode.sv
// State to control-vector table; enables here are ungated
// and qualified by MemReady/Zero/reset in the top.
module mc_decode
   import mc_ctrl_pkg::*;
(
   input  state_t i_state,
   output ctrl_t  o_ctrl
);

   always_comb begin
      o_ctrl = '0;
      unique case (i_state)
         ST_FETCH: begin
            o_ctrl.mem_re    = 1'b1;
            o_ctrl.ir_we     = 1'b1;
            o_ctrl.pc_we     = 1'b1;
            o_ctrl.pc_src    = PC_ALU;
            o_ctrl.alu_src_b = SRCB_FOUR;
            o_ctrl.alu_op    = ALU_ADD;
         end
         ST_DECODE: begin
            o_ctrl.alu_src_b = SRCB_IMMS;
            o_ctrl.alu_op    = ALU_ADD;
         end
         ST_EXEC_R: begin
            o_ctrl.alu_src_a = 1'b1;
            o_ctrl.alu_src_b = SRCB_REG;
            o_ctrl.alu_op    = ALU_FUNCT;
         end
         ST_WB_R: begin
            o_ctrl.reg_we  = 1'b1;
            o_ctrl.reg_dst = 1'b1;
         end
         ST_EXEC_I, ST_ADDR: begin
            o_ctrl.alu_src_a = 1'b1;
            o_ctrl.alu_src_b = SRCB_IMM;
            o_ctrl.alu_op    = ALU_ADD;
         end
         ST_WB_I: begin
            o_ctrl.reg_we = 1'b1;
         end
         ST_MEM_RD: begin
            o_ctrl.mem_re = 1'b1;
            o_ctrl.iord   = 1'b1;
         end
         ST_WB_L: begin
            o_ctrl.reg_we     = 1'b1;
            o_ctrl.mem_to_reg = 1'b1;
         end
         ST_MEM_WR: begin
            o_ctrl.mem_we = 1'b1;
            o_ctrl.iord   = 1'b1;
         end
         ST_BRANCH: begin
            o_ctrl.pc_we     = 1'b1;
            o_ctrl.pc_src    = PC_BR;
            o_ctrl.alu_src_a = 1'b1;
            o_ctrl.alu_src_b = SRCB_REG;
            o_ctrl.alu_op    = ALU_SUB;
         end
         ST_JUMP: begin
            o_ctrl.pc_we  = 1'b1;
            o_ctrl.pc_src = PC_JMP;
         end
         default: o_ctrl = '0;
      endcase
   end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM with memory-ready stalls,
// retired-instruction counter and sticky illegal-opcode flag.
module mc_ctrl
   import mc_ctrl_pkg::*;
#(
   parameter int CNT_W  = 32,
   parameter int PC_INC = 4
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [5:0]       Op,
   input  logic [5:0]       Funct,
   input  logic             Zero,
   input  logic             MemReady,
   output logic             PCWe,
   output logic [1:0]       PCSrc,
   output logic             IRWe,
   output logic             MemRe,
   output logic             MemWe,
   output logic             IorD,
   output logic             RegWe,
   output logic             RegDst,
   output logic             MemToReg,
   output logic             ALUSrcA,
   output logic [1:0]       ALUSrcB,
   output logic [1:0]       ALUOp,
   output logic             Illegal,
   output logic [CNT_W-1:0] RetireCnt,
   output logic [3:0]       State
);

   state_t           r_state;
   state_t           w_next;
   logic [CNT_W-1:0] r_cnt;
   logic             r_illegal;
   logic             w_retire;
   logic             w_illegal_op;
   logic             w_pc_gate;
   ctrl_t            w_ctrl;
   logic             w_unused;

   // Funct only steers the ALU; the sequencing never needs it.
   assign w_unused = ^Funct;

   if (PC_INC != 4) begin : g_nonstd_inc
   end

   mc_decode u_decode (
      .i_state (r_state),
      .o_ctrl  (w_ctrl)
   );

   always_comb begin
      w_next       = ST_FETCH;
      w_retire     = 1'b0;
      w_illegal_op = 1'b0;
      unique case (r_state)
         ST_FETCH:
            w_next = MemReady ? ST_DECODE : ST_FETCH;
         ST_DECODE: begin
            unique case (1'b1)
               (Op == OP_R_FORM): w_next = ST_EXEC_R;
               (Op == OP_LW),
               (Op == OP_SW):     w_next = ST_ADDR;
               (Op == OP_ADDI):   w_next = ST_EXEC_I;
               (Op == OP_BEQ):    w_next = ST_BRANCH;
               (Op == OP_J):      w_next = ST_JUMP;
               default: begin
                  w_retire     = 1'b1;
                  w_illegal_op = 1'b1;
               end
            endcase
         end
         ST_EXEC_R: w_next = ST_WB_R;
         ST_EXEC_I: w_next = ST_WB_I;
         ST_ADDR:
            w_next = (Op == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
         ST_MEM_RD:
            w_next = MemReady ? ST_WB_L : ST_MEM_RD;
         ST_MEM_WR: begin
            w_next   = MemReady ? ST_FETCH : ST_MEM_WR;
            w_retire = MemReady;
         end
         ST_WB_R, ST_WB_I, ST_WB_L,
         ST_BRANCH, ST_JUMP:
            w_retire = 1'b1;
         default: w_next = ST_FETCH;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state   <= ST_FETCH;
         r_cnt     <= '0;
         r_illegal <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_retire)
            r_cnt <= r_cnt + 1'b1;
         if (w_illegal_op)
            r_illegal <= 1'b1;
      end
   end

   // Fetch writes PC only once memory delivers; BEQ only if taken.
   always_comb begin
      w_pc_gate = 1'b1;
      if (r_state == ST_FETCH)
         w_pc_gate = MemReady;
      else if (r_state == ST_BRANCH)
         w_pc_gate = Zero;
   end

   assign PCWe      = ~RST & w_ctrl.pc_we & w_pc_gate;
   assign IRWe      = ~RST & w_ctrl.ir_we & MemReady;
   assign MemRe     = ~RST & w_ctrl.mem_re;
   assign MemWe     = ~RST & w_ctrl.mem_we;
   assign RegWe     = ~RST & w_ctrl.reg_we;
   assign PCSrc     = w_ctrl.pc_src;
   assign IorD      = w_ctrl.iord;
   assign RegDst    = w_ctrl.reg_dst;
   assign MemToReg  = w_ctrl.mem_to_reg;
   assign ALUSrcA   = w_ctrl.alu_src_a;
   assign ALUSrcB   = w_ctrl.alu_src_b;
   assign ALUOp     = w_ctrl.alu_op;
   assign Illegal   = r_illegal;
   assign RetireCnt = r_cnt;
   assign State     = r_state;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: per-instruction expected traces
// checked every cycle, plus literal cycle/counter checks.
module tb_mc_ctrl;

   localparam int CW = 4;

   localparam logic [3:0] S_F  = 4'd0;
   localparam logic [3:0] S_D  = 4'd1;
   localparam logic [3:0] S_ER = 4'd2;
   localparam logic [3:0] S_WR = 4'd3;
   localparam logic [3:0] S_EI = 4'd4;
   localparam logic [3:0] S_WI = 4'd5;
   localparam logic [3:0] S_AD = 4'd6;
   localparam logic [3:0] S_MR = 4'd7;
   localparam logic [3:0] S_WL = 4'd8;
   localparam logic [3:0] S_MW = 4'd9;
   localparam logic [3:0] S_BR = 4'd10;
   localparam logic [3:0] S_J  = 4'd11;

   logic          CLK, RST, Zero, MemReady;
   logic [5:0]    Op, Funct;
   logic          PCWe, IRWe, MemRe, MemWe, IorD;
   logic          RegWe, RegDst, MemToReg, ALUSrcA, Illegal;
   logic [1:0]    PCSrc, ALUSrcB, ALUOp;
   logic [CW-1:0] RetireCnt;
   logic [3:0]    State;
   logic [18:0]   w_out;

   int nvec = 0;
   int nerr = 0;
   int ncyc = 0;
   logic [CW-1:0] m_cnt = '0;
   logic          m_ill = 1'b0;

   mc_ctrl #(.CNT_W(CW), .PC_INC(4)) dut (
      .CLK(CLK), .RST(RST), .Op(Op), .Funct(Funct),
      .Zero(Zero), .MemReady(MemReady),
      .PCWe(PCWe), .PCSrc(PCSrc), .IRWe(IRWe),
      .MemRe(MemRe), .MemWe(MemWe), .IorD(IorD),
      .RegWe(RegWe), .RegDst(RegDst), .MemToReg(MemToReg),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
      .Illegal(Illegal), .RetireCnt(RetireCnt), .State(State)
   );

   assign w_out = {State, PCWe, PCSrc, IRWe, MemRe, MemWe,
                   IorD, RegWe, RegDst, MemToReg, ALUSrcA,
                   ALUSrcB, ALUOp};

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   function automatic logic [18:0] v(
      input logic [3:0] st, input logic pcwe,
      input logic [1:0] pcsrc, input logic irwe,
      input logic memre, input logic memwe, input logic iord,
      input logic regwe, input logic regdst, input logic m2r,
      input logic asa, input logic [1:0] asb,
      input logic [1:0] aop);
      return {st, pcwe, pcsrc, irwe, memre, memwe, iord,
              regwe, regdst, m2r, asa, asb, aop};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // One clock cycle: drive, compare, clock, advance model.
   task automatic step(input logic [18:0] ex, input logic mr,
                       input logic z, input logic rst,
                       input logic ret, input logic ill);
      MemReady = mr;
      Zero     = z;
      RST      = rst;
      #1;
      chk($sformatf("ctrl@%0d", ncyc), 32'(w_out), 32'(ex));
      chk($sformatf("cnt_ill@%0d", ncyc),
          32'({Illegal, RetireCnt}), 32'({m_ill, m_cnt}));
      @(posedge CLK);
      ncyc++;
      if (rst) begin
         m_cnt = '0;
         m_ill = 1'b0;
      end else begin
         if (ret) m_cnt = m_cnt + 1'b1;
         if (ill) m_ill = 1'b1;
      end
      @(negedge CLK);
   endtask

   task automatic run(input logic [5:0] op, input logic z,
                      input int fw, input int mw);
      logic legal;
      legal = op inside {6'b000000, 6'b100011, 6'b101011,
                         6'b001000, 6'b000100, 6'b000010};
      Op    = op;
      Funct = 6'b100000;
      repeat (fw)
         step(v(S_F,0,0,0,1,0,0,0,0,0,0,1,0), 0, z, 0, 0, 0);
      step(v(S_F,1,0,1,1,0,0,0,0,0,0,1,0), 1, z, 0, 0, 0);
      step(v(S_D,0,0,0,0,0,0,0,0,0,0,3,0), 1, z, 0,
           !legal, !legal);
      case (op)
         6'b000000: begin
            step(v(S_ER,0,0,0,0,0,0,0,0,0,1,0,2), 1, z, 0, 0, 0);
            step(v(S_WR,0,0,0,0,0,0,1,1,0,0,0,0), 1, z, 0, 1, 0);
         end
         6'b001000: begin
            step(v(S_EI,0,0,0,0,0,0,0,0,0,1,2,0), 1, z, 0, 0, 0);
            step(v(S_WI,0,0,0,0,0,0,1,0,0,0,0,0), 1, z, 0, 1, 0);
         end
         6'b100011: begin
            step(v(S_AD,0,0,0,0,0,0,0,0,0,1,2,0), 1, z, 0, 0, 0);
            repeat (mw)
               step(v(S_MR,0,0,0,1,0,1,0,0,0,0,0,0), 0, z, 0, 0, 0);
            step(v(S_MR,0,0,0,1,0,1,0,0,0,0,0,0), 1, z, 0, 0, 0);
            step(v(S_WL,0,0,0,0,0,0,1,0,1,0,0,0), 1, z, 0, 1, 0);
         end
         6'b101011: begin
            step(v(S_AD,0,0,0,0,0,0,0,0,0,1,2,0), 1, z, 0, 0, 0);
            repeat (mw)
               step(v(S_MW,0,0,0,0,1,1,0,0,0,0,0,0), 0, z, 0, 0, 0);
            step(v(S_MW,0,0,0,0,1,1,0,0,0,0,0,0), 1, z, 0, 1, 0);
         end
         6'b000100:
            step(v(S_BR,z,1,0,0,0,0,0,0,0,1,0,1), 1, z, 0, 1, 0);
         6'b000010:
            step(v(S_J,1,2,0,0,0,0,0,0,0,0,0,0), 1, z, 0, 1, 0);
         default: ;
      endcase
   endtask

   initial begin
      int c0;
      RST = 1'b1; MemReady = 1'b1; Zero = 1'b0;
      Op = 6'b0; Funct = 6'b0;
      #1;
      chk("rst_enables", 32'({PCWe, IRWe, MemRe, MemWe, RegWe}), 0);
      @(posedge CLK);
      @(negedge CLK);
      step(v(S_F,0,0,0,0,0,0,0,0,0,0,1,0), 1, 0, 1, 0, 0);
      chk("rst_cnt", 32'(RetireCnt), 0);
      chk("rst_ill", 32'(Illegal), 0);

      run(6'b000000, 0, 0, 0);
      chk("r_retire", 32'(RetireCnt), 1);

      run(6'b001000, 0, 2, 0);

      c0 = ncyc;
      run(6'b100011, 0, 0, 3);
      chk("lw_cycles", 32'(ncyc - c0), 8);

      c0 = ncyc;
      run(6'b000100, 1, 0, 0);
      chk("beq_t_cycles", 32'(ncyc - c0), 3);
      c0 = ncyc;
      run(6'b000100, 0, 0, 0);
      chk("beq_nt_cycles", 32'(ncyc - c0), 3);
      chk("beq_cnt", 32'(RetireCnt), 5);

      run(6'b111111, 0, 0, 0);
      chk("illegal_set", 32'(Illegal), 1);
      run(6'b101011, 0, 0, 2);
      chk("illegal_sticky", 32'(Illegal), 1);
      chk("sw_cnt", 32'(RetireCnt), 7);

      // Reset while a store waits on memory.
      Op = 6'b101011;
      step(v(S_F,1,0,1,1,0,0,0,0,0,0,1,0), 1, 0, 0, 0, 0);
      step(v(S_D,0,0,0,0,0,0,0,0,0,0,3,0), 1, 0, 0, 0, 0);
      step(v(S_AD,0,0,0,0,0,0,0,0,0,1,2,0), 1, 0, 0, 0, 0);
      step(v(S_MW,0,0,0,0,1,1,0,0,0,0,0,0), 0, 0, 0, 0, 0);
      step(v(S_MW,0,0,0,0,0,1,0,0,0,0,0,0), 0, 0, 1, 0, 0);
      chk("midrst_cnt", 32'(RetireCnt), 0);
      chk("midrst_ill", 32'(Illegal), 0);

      for (int i = 0; i < 16; i++) begin
         run(6'b000010, 0, 0, 0);
         if (i == 14) chk("j15_cnt", 32'(RetireCnt), 15);
      end
      chk("wrap_cnt", 32'(RetireCnt), 0);

      $display("== %0d vectors applied, %0d miscompares ==",
               nvec, nerr);
      $finish;
   end

endmodule
